// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, default datapath width and
// the occupancy states of the one-entry result buffer.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle of the shared ALU: two issue ports with valid/ready
// and one registered result port with valid/ready.
interface alu_share_arbiter_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);
    logic             req0_valid;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;

    logic             req1_valid;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_result;
    logic             resp_overflow;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_result, resp_overflow
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_result, resp_overflow
    );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: add, subtract, AND, OR with signed-overflow flag for the
// arithmetic operations.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);
    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;

    // Subtraction shares the adder as a + ~b + 1, so one overflow rule covers both.
    assign sub   = (op == ALU_SUB);
    assign b_eff = sub ? ~b : b;
    assign sum   = a + b_eff + WIDTH'(sub);

    // NOTE: both outputs get a default before the case, so no path leaves them unassigned (no latch).
    always_comb begin
        result   = sum;
        overflow = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB: overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                                         (sum[WIDTH-1] != a[WIDTH-1]);
            ALU_AND:          result = a & b;
            ALU_OR:           result = a | b;
            default:          result = sum;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; the result is
// held in a one-entry output buffer tagged with its owner.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    alu_share_arbiter_if.slave bus,
    output logic [CNT_W-1:0]   grant_cnt0,
    output logic [CNT_W-1:0]   grant_cnt1
);
    buf_state_e       state_q,      state_d;
    logic [WIDTH-1:0] result_q,     result_d;
    logic             overflow_q,   overflow_d;
    logic             id_q,         id_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt0_q,       cnt0_d;
    logic [CNT_W-1:0] cnt1_q,       cnt1_d;

    logic             can_issue;
    logic             grant_valid;
    logic             grant_id;
    alu_op_e          alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_overflow;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + CNT_W'(1);
    endfunction

    // A slot opens when the buffer is empty or drains this cycle; reset blocks any grant.
    always_comb begin
        can_issue   = !reset && ((state_q == BUF_EMPTY) || bus.resp_ready);
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (can_issue) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant_q;
            end else if (bus.req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    assign bus.req0_ready = grant_valid && !grant_id;
    assign bus.req1_ready = grant_valid &&  grant_id;

    assign alu_op = alu_op_e'(grant_id ? bus.req1_op : bus.req0_op);
    assign alu_a  = grant_id ? bus.req1_a : bus.req0_a;
    assign alu_b  = grant_id ? bus.req1_b : bus.req0_b;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .op       (alu_op),
        .a        (alu_a),
        .b        (alu_b),
        .result   (alu_result),
        .overflow (alu_overflow)
    );

    always_comb begin
        state_d      = state_q;
        result_d     = result_q;
        overflow_d   = overflow_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        if (grant_valid) begin
            state_d      = BUF_FULL;
            result_d     = alu_result;
            overflow_d   = alu_overflow;
            id_d         = grant_id;
            last_grant_d = grant_id;
            if (grant_id) cnt1_d = sat_inc(cnt1_q);
            else          cnt0_d = sat_inc(cnt0_q);
        end else if ((state_q == BUF_FULL) && bus.resp_ready) begin
            state_d = BUF_EMPTY;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= BUF_EMPTY;
            result_q     <= '0;
            overflow_q   <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;  // requester 0 wins the first contention
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            result_q     <= result_d;
            overflow_q   <= overflow_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign bus.resp_valid    = (state_q == BUF_FULL);
    assign bus.resp_id       = id_q;
    assign bus.resp_result   = result_q;
    assign bus.resp_overflow = overflow_q;
    assign grant_cnt0        = cnt0_q;
    assign grant_cnt1        = cnt1_q;

endmodule
